// File: rtl/mux_nx1_pipe.sv
// Parametrised N:1 channel multiplexer with a single registered output stage
// and valid/ready handshakes on both sides. Channels are chosen manually via
// sel, or by an internal round-robin pointer in auto-scan mode. Out-of-range
// selects yield zero data, flag the beat and bump a saturating error count.
module mux_nx1_pipe #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 1,
    parameter int unsigned SELW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*W-1:0]    in_data,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              sel_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        err_cnt
);

    localparam int unsigned    CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SELW-1:0]  LAST_CH = SELW'(N - 1);

    // Parameter sanity checks at elaboration time
    if (N < 2) begin : g_bad_n
        $error("mux_nx1_pipe: N must be at least 2");
    end
    if (W < 1) begin : g_bad_w
        $error("mux_nx1_pipe: W must be at least 1");
    end
    if ((64'(1) << SELW) < 64'(N)) begin : g_bad_selw
        $error("mux_nx1_pipe: SELW too narrow to address N channels");
    end

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              in_range;
    logic [SELW-1:0]   sel_eff;
    logic [SELW-1:0]   scan_ptr;
    logic [W-1:0]      picked;

    // Handshake: a free or draining output slot accepts a new beat
    assign out_valid = (state == ST_FULL);
    assign in_ready  = (state == ST_EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign sel_eff   = mode ? scan_ptr : sel;
    assign in_range  = 32'(sel_eff) < N;

    // Channel selection; out-of-range indices fall through to zero
    always_comb begin
        picked = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel_eff == SELW'(k)) begin
                picked = in_data[k*W +: W];
            end
        end
    end

    // Output-slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output-slot next state: fill on accept, empty on drain without refill
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!accept && out_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Output payload registers load only on accept and hold otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_chan <= '0;
            sel_err  <= 1'b0;
        end else if (accept) begin
            out_data <= in_range ? picked : '0;
            out_chan <= sel_eff;
            sel_err  <= !in_range;
        end
    end

    // Round-robin pointer advances per auto-scan beat, wrapping at the last channel
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_ptr <= '0;
        end else if (accept && mode) begin
            scan_ptr <= (scan_ptr == LAST_CH) ? '0 : scan_ptr + SELW'(1);
        end
    end

    // Saturating count of out-of-range beats
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (accept && !in_range && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
